// File: rtl/ofdm_rx_cp_strip.sv
// rtl/ofdm_rx_cp_strip.sv - OFDM receive cyclic-prefix strip and offset-binary to complex packer
module ofdm_rx_cp_strip #(
  parameter int NFFT   = 16,
  parameter int CP_LEN = 2,
  parameter int W      = 16
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [W-1:0]   s_axis_data_tdata,
  input  logic           s_axis_data_tvalid,
  input  logic           s_axis_data_tlast,
  output logic           s_axis_data_tready,
  output logic [2*W-1:0] m_axis_data_tdata,
  output logic [7:0]     m_axis_data_tuser,
  output logic           m_axis_data_tvalid,
  output logic           m_axis_data_tlast,
  input  logic           m_axis_data_tready,
  output logic [15:0]    symbol_count,
  output logic           align_error
);

  typedef enum logic {CP_SKIP = 1'b0, DATA = 1'b1} state_t;

  localparam logic [7:0] CP_LAST   = 8'(CP_LEN - 1);
  localparam logic [7:0] NFFT_LAST = 8'(NFFT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       accept, load, err_nxt;
  logic       at_cp_end, at_data_end;

  // Ready is held low throughout reset; in DATA it follows the single output slot.
  assign s_axis_data_tready = aresetn &
                              ((state == CP_SKIP) | ~m_axis_data_tvalid | m_axis_data_tready);
  assign accept      = s_axis_data_tvalid & s_axis_data_tready;
  assign at_cp_end   = (cnt == CP_LAST);
  assign at_data_end = (cnt == NFFT_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= CP_SKIP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CP_SKIP: begin
        if (accept) begin
          if (s_axis_data_tlast || at_cp_end) cnt_nxt = '0;
          else                                cnt_nxt = cnt + 8'd1;
          if (!s_axis_data_tlast && at_cp_end) state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (s_axis_data_tlast || at_data_end) begin
            cnt_nxt   = '0;
            state_nxt = CP_SKIP;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = CP_SKIP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A framing error is any disagreement between s_tlast and the locally counted symbol end.
  always_comb begin
    load    = 1'b0;
    err_nxt = 1'b0;
    case (state)
      CP_SKIP: err_nxt = accept & s_axis_data_tlast;
      DATA: begin
        load    = accept;
        err_nxt = accept & (s_axis_data_tlast ^ at_data_end);
      end
      default: begin
        load    = 1'b0;
        err_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_data_tdata  <= '0;
      m_axis_data_tuser  <= '0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tlast  <= 1'b0;
      symbol_count       <= '0;
      align_error        <= 1'b0;
    end else begin
      align_error <= err_nxt;
      if (load) begin
        m_axis_data_tdata  <= {{W{1'b0}}, ~s_axis_data_tdata[W-1], s_axis_data_tdata[W-2:0]};
        m_axis_data_tuser  <= cnt;
        m_axis_data_tlast  <= at_data_end | s_axis_data_tlast;
        m_axis_data_tvalid <= 1'b1;
      end else if (m_axis_data_tready) begin
        m_axis_data_tvalid <= 1'b0;
      end
      if (load && at_data_end) symbol_count <= symbol_count + 16'd1;
    end
  end

endmodule

// File: doc/ofdm_rx_cp_strip.md
Name: ofdm_rx_cp_strip

Overview:
Receive-side counterpart of the transmit IFFT manager. Accepts the unsigned offset-binary real time-domain stream produced at the transmitter output and converts each sample to two's complement. Discards the cyclic prefix of each OFDM symbol and packs the remaining NFFT samples into 32-bit complex words (imag = 0) on an AXI-Stream master with bin index and tlast, ready for the FFT core.

Parameters:
NFFT, 16, useful samples per OFDM symbol (power of 2, 4..256)
CP_LEN, 2, cyclic-prefix samples per symbol (1..NFFT-1)
W, 16, sample width in bits

Ports:
aclk  in  1  system clock, rising edge
aresetn  in  1  reset; one clock, asynchronous assert, active-low
s_axis_data_tdata  in  W  unsigned offset-binary real sample
s_axis_data_tvalid  in  1  input sample valid
s_axis_data_tlast  in  1  last sample of symbol (CP_LEN+NFFT-th sample)
s_axis_data_tready  out  1  input ready
m_axis_data_tdata  out  2W  {imag[W-1:0]=0, real[W-1:0]} two's complement
m_axis_data_tuser  out  8  bin index 0..NFFT-1
m_axis_data_tvalid  out  1  output valid
m_axis_data_tlast  out  1  last bin of symbol
m_axis_data_tready  in  1  downstream ready
symbol_count  out  16  completed symbols, wraps 0xFFFF->0
align_error  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (aresetn=0, async): state=CP_SKIP, cnt=0, all m_axis outputs 0, symbol_count=0, align_error=0. s_axis_data_tready=0 while in reset.
- Input accept = s_tvalid & s_tready. Output transfer = m_tvalid & m_tready.
- Conversion: real = {~s_tdata[W-1], s_tdata[W-2:0]}; imag = 0. Examples: 0x8000->0x0000, 0xFFFF->0x7FFF, 0x0000->0x8000, 0x8020->0x0020.
- Single output register stage; latency is 1 cycle from input accept to m_tvalid.
- States:
  - CP_SKIP: s_tready=1. Each accept drops the sample and increments cnt. On an accept with cnt==CP_LEN-1: cnt<=0, go to DATA.
  - DATA: s_tready = ~m_tvalid | m_tready. Each accept loads the output register: tdata=converted sample, tuser=cnt, tlast=(cnt==NFFT-1), m_tvalid<=1. On an accept with cnt==NFFT-1: cnt<=0, symbol_count++, go to CP_SKIP. Otherwise cnt++.
- m_tvalid clears after a transfer with no new load in the same cycle. Simultaneous transfer and load is allowed (full throughput, 1 sample/clock).
- Output holds stable while m_tvalid=1 and m_tready=0. CP samples are still consumed during DATA backpressure only after the state returns to CP_SKIP, and the output register is not touched in CP_SKIP.
- Framing via s_tlast:
  - Accept with s_tlast=1 in CP_SKIP: sample dropped; align_error pulse; cnt<=0; stay in CP_SKIP.
  - Accept with s_tlast=1 in DATA with cnt<NFFT-1: sample forwarded with m_tlast=1; align_error pulse; symbol_count unchanged; cnt<=0; go to CP_SKIP.
  - Accept in DATA with cnt==NFFT-1 and s_tlast=0: normal completion, plus an align_error pulse.
- align_error is registered and asserts the cycle after the offending accept.
- Reset mid-symbol discards any pending output word immediately (m_tvalid=0) and restarts in CP_SKIP.

Test Plan:
- Reset: hold aresetn=0 for 10 cycles with s_tvalid=1 -> s_tready=0, m_tvalid=0, symbol_count=0, align_error=0. The outputs clear asynchronously, mid-cycle.
- One symbol with m_tready=1: 18 samples 0x0000,0x0001,0x8000,0x8020,0xFFFF,... with tlast on the 18th -> first 2 dropped; 16 outputs tuser 0..15 with data 0x00000000, 0x00000020, 0x00007FFF...; tlast only on tuser=15; symbol_count=1; no align_error; each output 1 cycle after its input.
- Backpressure: m_tready random at 50%, 3 back-to-back symbols -> no loss or duplication; tdata/tuser stable while stalled; symbol_count=3; every output bin sequence is 0..15.
- Early tlast: s_tlast on the 10th sample of a symbol (DATA cnt=7) -> output tuser=7 with tlast=1, align_error pulse, symbol_count unchanged. The next 18-sample symbol aligns correctly.
- tlast during CP and missing final tlast -> one align_error pulse each; the stream realigns as specified.
- Reset asserted at bin 5 with m_tready=0 -> m_tvalid drops immediately. After release, a full symbol is processed from CP_SKIP.
